// File: rtl/m_pkg.sv
// Shared definitions for the RV32M multiply/divide sequencer: op codes, FSM states and the
// default datapath width.
package m_pkg;
    localparam int unsigned XLEN_DEFAULT = 32;

    typedef enum logic [2:0] {
        OpMul    = 3'b000,
        OpMulh   = 3'b001,
        OpMulhsu = 3'b010,
        OpMulhu  = 3'b011,
        OpDiv    = 3'b100,
        OpDivu   = 3'b101,
        OpRem    = 3'b110,
        OpRemu   = 3'b111
    } m_op_e;

    typedef enum logic [1:0] {
        StIdle,
        StIter,
        StFin
    } state_e;

    function automatic logic op_is_div(m_op_e op);
        return op[2];
    endfunction

    function automatic logic op_is_rem(m_op_e op);
        return op[2] & op[1];
    endfunction

    function automatic logic op_a_signed(m_op_e op);
        return op inside {OpMul, OpMulh, OpMulhsu, OpDiv, OpRem};
    endfunction

    function automatic logic op_b_signed(m_op_e op);
        return op inside {OpMul, OpMulh, OpDiv, OpRem};
    endfunction
endpackage

// File: rtl/muldiv_negate.sv
// Conditional two's-complement negate, used both for operand magnitudes and result fix-up.
module muldiv_negate #(
    parameter int unsigned Width = 32
) (
    input  logic             neg_i,
    input  logic [Width-1:0] val_i,
    output logic [Width-1:0] val_o
);
    assign val_o = neg_i ? (~val_i + Width'(1)) : val_i;
endmodule

// File: rtl/muldiv_seq.sv
// RV32M multi-cycle multiply/divide sequencer: radix-2 shift-add multiply and restoring
// divide on magnitudes, RISC-V sign and corner-case handling, one-cycle done pulse.
module muldiv_seq
    import m_pkg::*;
#(
    parameter int unsigned XLEN = XLEN_DEFAULT
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            start_i,
    input  logic [2:0]      m_op_i,
    input  logic [XLEN-1:0] rs1_i,
    input  logic [XLEN-1:0] rs2_i,
    input  logic            flush_i,
    output logic            ready_o,
    output logic            busy_o,
    output logic            done_o,
    output logic [XLEN-1:0] result_o
);
    localparam int unsigned CntW = $clog2(XLEN) + 1;

    state_e            state_q;
    m_op_e             op_q;
    logic              negq_q, negr_q, special_q, done_q;
    logic [CntW-1:0]   cnt_q;
    logic [XLEN:0]     hi_q, hi_d;
    logic [XLEN-1:0]   lo_q, lo_d, m_q, result_q;

    m_op_e             op_in;
    logic              sign_a, sign_b, div_zero, div_ovf, special;
    logic [XLEN-1:0]   a_mag, b_mag, special_res;
    logic [XLEN:0]     mul_sum, div_shift, div_diff;
    logic [2*XLEN-1:0] prod_fix;
    logic [XLEN-1:0]   div_raw, div_fix, fin_res;
    logic              div_neg;

    assign op_in  = m_op_e'(m_op_i);
    assign sign_a = op_a_signed(op_in) & rs1_i[XLEN-1];
    assign sign_b = op_b_signed(op_in) & rs2_i[XLEN-1];

    muldiv_negate #(.Width(XLEN)) u_neg_a (.neg_i(sign_a), .val_i(rs1_i), .val_o(a_mag));
    muldiv_negate #(.Width(XLEN)) u_neg_b (.neg_i(sign_b), .val_i(rs2_i), .val_o(b_mag));

    assign div_zero = op_is_div(op_in) && (rs2_i == '0);
    assign div_ovf  = (op_in == OpDiv || op_in == OpRem)
                      && (rs1_i == {1'b1, {(XLEN-1){1'b0}}}) && (rs2_i == '1);
    assign special  = div_zero || div_ovf;

    always_comb begin
        special_res = '0;
        if (div_zero) begin
            special_res = op_is_rem(op_in) ? rs1_i : '1;
        end else if (div_ovf) begin
            special_res = op_is_rem(op_in) ? '0 : rs1_i;
        end
    end

    // Multiply: hi accumulates, lo holds the multiplier shifting out as product bits shift in.
    // Divide: hi is the partial remainder, lo holds the dividend shifting out / quotient in.
    always_comb begin
        mul_sum   = lo_q[0] ? (hi_q + {1'b0, m_q}) : hi_q;
        div_shift = {hi_q[XLEN-1:0], lo_q[XLEN-1]};
        div_diff  = div_shift - {1'b0, m_q};
        hi_d      = {1'b0, mul_sum[XLEN:1]};
        lo_d      = {mul_sum[0], lo_q[XLEN-1:1]};
        if (op_is_div(op_q)) begin
            hi_d = div_diff[XLEN] ? div_shift : div_diff;
            lo_d = {lo_q[XLEN-2:0], ~div_diff[XLEN]};
        end
    end

    muldiv_negate #(.Width(2*XLEN)) u_neg_prod (
        .neg_i(negq_q),
        .val_i({hi_q[XLEN-1:0], lo_q}),
        .val_o(prod_fix)
    );

    assign div_raw = op_is_rem(op_q) ? hi_q[XLEN-1:0] : lo_q;
    assign div_neg = op_is_rem(op_q) ? negr_q : negq_q;

    muldiv_negate #(.Width(XLEN)) u_neg_div (.neg_i(div_neg), .val_i(div_raw), .val_o(div_fix));

    always_comb begin
        fin_res = prod_fix[2*XLEN-1:XLEN];
        if (special_q) begin
            fin_res = lo_q;
        end else if (op_is_div(op_q)) begin
            fin_res = div_fix;
        end else if (op_q == OpMul) begin
            fin_res = prod_fix[XLEN-1:0];
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q   <= StIdle;
            op_q      <= OpMul;
            negq_q    <= 1'b0;
            negr_q    <= 1'b0;
            special_q <= 1'b0;
            done_q    <= 1'b0;
            cnt_q     <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
            m_q       <= '0;
            result_q  <= '0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (start_i && !flush_i) begin
                        op_q      <= op_in;
                        negq_q    <= sign_a ^ sign_b;
                        negr_q    <= sign_a;
                        special_q <= special;
                        cnt_q     <= '0;
                        hi_q      <= '0;
                        m_q       <= op_is_div(op_in) ? b_mag : a_mag;
                        if (special) begin
                            lo_q    <= special_res;
                            state_q <= StFin;
                        end else begin
                            lo_q    <= op_is_div(op_in) ? a_mag : b_mag;
                            state_q <= StIter;
                        end
                    end
                end
                StIter: begin
                    if (flush_i) begin
                        state_q <= StIdle;
                        cnt_q   <= '0;
                    end else begin
                        hi_q <= hi_d;
                        lo_q <= lo_d;
                        if (cnt_q == CntW'(XLEN - 1)) begin
                            cnt_q   <= '0;
                            state_q <= StFin;
                        end else begin
                            cnt_q <= cnt_q + CntW'(1);
                        end
                    end
                end
                StFin: begin
                    state_q <= StIdle;
                    if (!flush_i) begin
                        done_q   <= 1'b1;
                        result_q <= fin_res;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign ready_o  = (state_q == StIdle);
    assign busy_o   = (state_q != StIdle);
    assign done_o   = done_q;
    assign result_o = result_q;
endmodule

// File: tb/tb_muldiv_seq.sv
// Directed bench for muldiv_seq: latency, results per op, divide corner cases, ignored start,
// flush and mid-operation reset.
module tb_muldiv_seq;
    localparam logic [2:0] OP_MUL    = 3'b000;
    localparam logic [2:0] OP_MULH   = 3'b001;
    localparam logic [2:0] OP_MULHSU = 3'b010;
    localparam logic [2:0] OP_MULHU  = 3'b011;
    localparam logic [2:0] OP_DIV    = 3'b100;
    localparam logic [2:0] OP_DIVU   = 3'b101;
    localparam logic [2:0] OP_REM    = 3'b110;
    localparam logic [2:0] OP_REMU   = 3'b111;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        flush = 1'b0;
    logic [2:0]  m_op = 3'b000;
    logic [31:0] rs1 = '0;
    logic [31:0] rs2 = '0;
    logic        ready, busy, done;
    logic [31:0] result;

    int n_checks = 0;
    int n_fail = 0;

    muldiv_seq #(.XLEN(32)) dut (
        .clk_i   (clk),
        .rst_ni  (rst_n),
        .start_i (start),
        .m_op_i  (m_op),
        .rs1_i   (rs1),
        .rs2_i   (rs2),
        .flush_i (flush),
        .ready_o (ready),
        .busy_o  (busy),
        .done_o  (done),
        .result_o(result)
    );

    always #5 clk = ~clk;

    // Issues one request and returns the result plus the number of edges from accept to done
    // (-1 if done never came within the budget).
    task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] res, output int lat);
        @(negedge clk);
        start = 1'b1; m_op = op; rs1 = a; rs2 = b;
        @(posedge clk);
        #1 start = 1'b0;
        lat = -1;
        res = '0;
        for (int k = 1; k <= 60 && lat < 0; k++) begin
            @(posedge clk);
            #1;
            if (done) begin
                lat = k;
                res = result;
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_checks++; if (ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready got %b want 1", ready); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b want 0", busy); end
        n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done got %b want 0", done); end
        n_checks++; if (result !== 32'h0) begin n_fail++; $display("FAIL reset_result got %h want 0", result); end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_mul_timing();
        int          lat = -1;
        logic [31:0] res = '0;
        bit          bad_busy = 0;
        bit          bad_ready = 0;
        @(negedge clk);
        start = 1'b1; m_op = OP_MUL; rs1 = 32'd7; rs2 = 32'hFFFFFFFD;
        @(posedge clk);
        #1 start = 1'b0;
        for (int k = 1; k <= 40 && lat < 0; k++) begin
            @(posedge clk);
            #1;
            if (done) begin
                lat = k;
                res = result;
            end else begin
                if (busy !== 1'b1) bad_busy = 1;
                if (ready !== 1'b0) bad_ready = 1;
            end
        end
        n_checks++; if (lat != 33) begin n_fail++; $display("FAIL mul_latency got %0d want 33", lat); end
        n_checks++; if (res !== 32'hFFFFFFEB) begin n_fail++; $display("FAIL mul_result got %h want ffffffeb", res); end
        n_checks++; if (bad_busy) begin n_fail++; $display("FAIL mul_busy got low want high while running"); end
        n_checks++; if (bad_ready) begin n_fail++; $display("FAIL mul_ready got high want low while running"); end
        @(posedge clk);
        #1;
        n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL mul_done_pulse got %b want 0", done); end
        n_checks++; if (ready !== 1'b1) begin n_fail++; $display("FAIL mul_ready_after got %b want 1", ready); end
        n_checks++; if (result !== 32'hFFFFFFEB) begin n_fail++; $display("FAIL mul_result_held got %h want ffffffeb", result); end
    endtask

    task automatic test_mul_high();
        logic [2:0]  ops[3] = '{OP_MULH, OP_MULHU, OP_MULHSU};
        logic [31:0] as[3]  = '{32'h80000000, 32'hFFFFFFFF, 32'hFFFFFFFF};
        logic [31:0] bs[3]  = '{32'h80000000, 32'hFFFFFFFF, 32'hFFFFFFFF};
        logic [31:0] exp[3] = '{32'h40000000, 32'hFFFFFFFE, 32'hFFFFFFFF};
        logic [31:0] res;
        int          lat;
        for (int i = 0; i < 3; i++) begin
            issue(ops[i], as[i], bs[i], res, lat);
            n_checks++; if (res !== exp[i]) begin n_fail++; $display("FAIL mulhigh_%0d got %h want %h", i, res, exp[i]); end
            n_checks++; if (lat != 33) begin n_fail++; $display("FAIL mulhigh_lat_%0d got %0d want 33", i, lat); end
        end
    endtask

    task automatic test_div();
        logic [2:0]  ops[4] = '{OP_DIV, OP_REM, OP_DIVU, OP_REMU};
        logic [31:0] as[4]  = '{32'hFFFFFFF9, 32'hFFFFFFF9, 32'd100, 32'd100};
        logic [31:0] bs[4]  = '{32'd2, 32'd2, 32'd7, 32'd7};
        logic [31:0] exp[4] = '{32'hFFFFFFFD, 32'hFFFFFFFF, 32'd14, 32'd2};
        logic [31:0] res;
        int          lat;
        for (int i = 0; i < 4; i++) begin
            issue(ops[i], as[i], bs[i], res, lat);
            n_checks++; if (res !== exp[i]) begin n_fail++; $display("FAIL div_%0d got %h want %h", i, res, exp[i]); end
            n_checks++; if (lat != 33) begin n_fail++; $display("FAIL div_lat_%0d got %0d want 33", i, lat); end
        end
    endtask

    task automatic test_special();
        logic [2:0]  ops[4] = '{OP_DIVU, OP_REM, OP_DIV, OP_REM};
        logic [31:0] as[4]  = '{32'd5, 32'd5, 32'h80000000, 32'h80000000};
        logic [31:0] bs[4]  = '{32'd0, 32'd0, 32'hFFFFFFFF, 32'hFFFFFFFF};
        logic [31:0] exp[4] = '{32'hFFFFFFFF, 32'd5, 32'h80000000, 32'h0};
        logic [31:0] res;
        int          lat;
        for (int i = 0; i < 4; i++) begin
            issue(ops[i], as[i], bs[i], res, lat);
            n_checks++; if (res !== exp[i]) begin n_fail++; $display("FAIL special_%0d got %h want %h", i, res, exp[i]); end
            n_checks++; if (lat != 1) begin n_fail++; $display("FAIL special_lat_%0d got %0d want 1", i, lat); end
        end
    endtask

    // Each request is driven as soon as the previous done is seen, so accepts land at the
    // minimum spacing.
    task automatic test_back_to_back();
        logic [31:0] res;
        int          lat;
        issue(OP_DIV, 32'd9, 32'd0, res, lat);
        n_checks++; if (res !== 32'hFFFFFFFF || lat != 1) begin n_fail++; $display("FAIL b2b_special got %h/%0d want ffffffff/1", res, lat); end
        issue(OP_REMU, 32'd77, 32'd0, res, lat);
        n_checks++; if (res !== 32'd77 || lat != 1) begin n_fail++; $display("FAIL b2b_special2 got %h/%0d want 0000004d/1", res, lat); end
        issue(OP_MUL, 32'd3, 32'd5, res, lat);
        n_checks++; if (res !== 32'd15 || lat != 33) begin n_fail++; $display("FAIL b2b_mul got %h/%0d want 0000000f/33", res, lat); end
        issue(OP_MUL, 32'h0, 32'h12345678, res, lat);
        n_checks++; if (res !== 32'h0 || lat != 33) begin n_fail++; $display("FAIL b2b_mulzero got %h/%0d want 00000000/33", res, lat); end
    endtask

    task automatic test_ignore_start();
        int          lat = -1;
        logic [31:0] res = '0;
        @(negedge clk);
        start = 1'b1; m_op = OP_DIVU; rs1 = 32'd100; rs2 = 32'd7;
        @(posedge clk);
        #1 start = 1'b0;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (k == 5) begin
                start = 1'b1; m_op = OP_REMU; rs1 = 32'd50; rs2 = 32'd3;
            end else begin
                start = 1'b0;
            end
            @(posedge clk);
            #1;
            if (done && lat < 0) begin
                lat = k;
                res = result;
            end
        end
        start = 1'b0;
        n_checks++; if (res !== 32'd14) begin n_fail++; $display("FAIL ignore_result got %h want 0000000e", res); end
        n_checks++; if (lat != 33) begin n_fail++; $display("FAIL ignore_latency got %0d want 33", lat); end
    endtask

    task automatic test_flush();
        bit saw_done = 0;
        @(negedge clk);
        start = 1'b1; m_op = OP_MUL; rs1 = 32'd3; rs2 = 32'd5;
        @(posedge clk);
        #1 start = 1'b0;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            flush = (k == 10);
            @(posedge clk);
            #1;
            if (done) saw_done = 1;
            if (k == 10) begin
                n_checks++; if (ready !== 1'b1) begin n_fail++; $display("FAIL flush_ready got %b want 1", ready); end
                n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL flush_busy got %b want 0", busy); end
            end
        end
        flush = 1'b0;
        n_checks++; if (saw_done) begin n_fail++; $display("FAIL flush_done got pulse want none"); end
        n_checks++; if (result !== 32'd14) begin n_fail++; $display("FAIL flush_result got %h want 0000000e", result); end
        // flush together with start in IDLE discards the request
        saw_done = 0;
        @(negedge clk);
        start = 1'b1; flush = 1'b1; m_op = OP_MUL; rs1 = 32'd2; rs2 = 32'd2;
        @(posedge clk);
        #1;
        start = 1'b0; flush = 1'b0;
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL discard_busy got %b want 0", busy); end
        for (int k = 0; k < 40; k++) begin
            @(posedge clk);
            #1;
            if (done) saw_done = 1;
        end
        n_checks++; if (saw_done) begin n_fail++; $display("FAIL discard_done got pulse want none"); end
    endtask

    task automatic test_reset_mid();
        logic [31:0] res;
        int          lat;
        bit          saw_done = 0;
        @(negedge clk);
        start = 1'b1; m_op = OP_DIV; rs1 = 32'd1000; rs2 = 32'd3;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (19) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        n_checks++; if (ready !== 1'b1) begin n_fail++; $display("FAIL rstmid_ready got %b want 1", ready); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rstmid_busy got %b want 0", busy); end
        n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL rstmid_done got %b want 0", done); end
        n_checks++; if (result !== 32'h0) begin n_fail++; $display("FAIL rstmid_result got %h want 0", result); end
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 20; k++) begin
            @(posedge clk);
            #1;
            if (done) saw_done = 1;
        end
        n_checks++; if (saw_done) begin n_fail++; $display("FAIL rstmid_no_done got pulse want none"); end
        issue(OP_MUL, 32'd3, 32'd4, res, lat);
        n_checks++; if (res !== 32'd12) begin n_fail++; $display("FAIL rstmid_mul got %h want 0000000c", res); end
        n_checks++; if (lat != 33) begin n_fail++; $display("FAIL rstmid_mul_lat got %0d want 33", lat); end
    endtask

    initial begin
        test_reset();
        test_mul_timing();
        test_mul_high();
        test_div();
        test_special();
        test_back_to_back();
        test_ignore_start();
        test_flush();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
